timer_irq_ctrl: RTL and testbench
=================================

# timer_irq_ctrl

Machine-timer interrupt source for the 3-stage core; it drives the `trap_handle` input of the CSR unit and consumes that unit's `epc_taken` and `is_mret` signals. It holds a 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, both memory-mapped on the LSU data bus. It raises a level interrupt request when `mtime >= mtimecmp` and tracks the request through acceptance and `mret`. It also supplies the `mtip` pending bit that firmware mirrors into `mip[7]`.

## Interface
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clk cycles; legal range 1..65535.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  32  LSU byte address.
- `wdata`  in  32  LSU store data.
- `wr_en`  in  1  store strobe, full-word only.
- `rd_en`  in  1  load strobe.
- `rdata`  out  32  load data; combinational.
- `epc_taken`  in  1  from the CSR unit: the trap was accepted this cycle.
- `is_mret`  in  1  from decode: an MRET is retiring.
- `trap_handle`  out  1  interrupt request to the CSR unit; registered.
- `mtip`  out  1  registered result of `mtime >= mtimecmp`.

## Operation
- Address map (word-aligned, little-endian halves):
  - `0x0200_4000` = `mtimecmp[31:0]`
  - `0x0200_4004` = `mtimecmp[63:32]`
  - `0x0200_BFF8` = `mtime[31:0]`
  - `0x0200_BFFC` = `mtime[63:32]`
  - Reads of any other address return 0. Writes to any other address are ignored.
- Reset values:
  - `mtime` = 0, `mtimecmp` = all-ones, prescale counter = 0.
  - state = IDLE, `trap_handle` = 0, `mtip` = 0.
  - `rdata` = 0 unless `rd_en` is high.
- Counter:
  - The prescale counter counts 0..`PRESCALE-1`. `mtime` increments when the counter wraps.
  - 64-bit add; carry propagates from the low word to the high word; `mtime` wraps from all-ones to 0.
- Write priority: an `mtime` half written in a cycle takes the written value. The increment is dropped for that half, and for the carry into it.
- Compare: unsigned 64-bit `>=`, evaluated on the current register values. `mtip` registers the result every cycle.
- FSM states:
  - IDLE: if `mtip`, go to PENDING.
  - PENDING (`trap_handle` = 1):
    - `epc_taken` → SERVICE.
    - Otherwise, `!mtip` (firmware moved `mtimecmp` ahead) → IDLE (request withdrawn).
  - SERVICE (`trap_handle` = 0): `is_mret` → IDLE. IDLE re-raises the request on the next cycle if `mtip` is still set.
- `is_mret` is ignored in IDLE and PENDING. `epc_taken` is ignored outside PENDING.
- Simultaneous `epc_taken` and `!mtip` in PENDING: `epc_taken` wins, go to SERVICE.
- Reset asserted mid-PENDING or mid-SERVICE: immediate return to IDLE with `trap_handle` = 0; no residue.

## Timing
- Writes take effect at the next rising edge. Reads are same-cycle combinational.
- Latency from compare to request:
  - Compare becomes true after edge k.
  - `mtip` = 1 after edge k+1.
  - `trap_handle` = 1 after edge k+2.
- `trap_handle` falls on the edge that samples `epc_taken`, so it is low in the cycle after acceptance. The CSR unit writes on the negedge, so it samples a stable level.
- After MRET, the minimum gap before a re-raised request is 2 cycles: SERVICE→IDLE, then IDLE→PENDING.
- 64-bit reads are not atomic. Software reads hi, lo, hi and retries on mismatch; the hardware gives no snapshot.

## Structure
- `timer_pkg`:
  - `typedef enum logic [1:0] {IDLE, PENDING, SERVICE} tirq_state_e`
  - address constants `MTIMECMP_LO`, `MTIMECMP_HI`, `MTIME_LO`, `MTIME_HI`
- Sub-module `mtime_counter`: prescaler, 64-bit counter, and per-half write ports with write-over-increment priority. It has `mtime` as its output.
- Top level holds `mtimecmp`, the comparator, the FSM and the read mux.

## Test plan
- Reset, then read all four addresses → `mtime` = 0, `mtimecmp` = `0xFFFF_FFFF` (both halves); `trap_handle` = 0.
- `PRESCALE` = 1, write `mtimecmp` = 10 (lo), 0 (hi) → `mtip` rises 1 cycle after `mtime` reaches 10; `trap_handle` rises 1 cycle later.
- While PENDING, pulse `epc_taken` → `trap_handle` = 0 next cycle. Write `mtimecmp` = 0x100, then pulse `is_mret` → state IDLE, no re-raise.
- While PENDING, write `mtimecmp` = all-ones with no `epc_taken` → request withdrawn, IDLE within 2 cycles. The same cycle with `epc_taken` also high → SERVICE.
- Write `mtime` = `0x0000_0000_FFFF_FFFF` → next increment gives hi = 1, lo = 0. Write all-ones → wraps to 0.
- Assert `rst` asynchronously mid-SERVICE → `trap_handle`, `mtip` = 0 and `mtime` = 0 before the next clk edge.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared types and address map for the machine-timer interrupt block.
//   tirq_state_e : interrupt-request FSM states
//   MTIMECMP_LO/HI, MTIME_LO/HI : word addresses on the LSU data bus
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } tirq_state_e;

  localparam logic [31:0] MTIMECMP_LO = 32'h0200_4000;
  localparam logic [31:0] MTIMECMP_HI = 32'h0200_4004;
  localparam logic [31:0] MTIME_LO    = 32'h0200_BFF8;
  localparam logic [31:0] MTIME_HI    = 32'h0200_BFFC;

endpackage

// File: rtl/mtime_counter.sv
// mtime_counter: prescaler plus 64-bit free-running mtime with per-half writes.
//   clk, rst          : clock, async active-high reset
//   wr_lo_i, wr_hi_i  : load mtime[31:0] / mtime[63:32] from wdata_i this edge
//   wdata_i           : store data
//   mtime_o           : current mtime value
module mtime_counter #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] mtime_o
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        tick;
  logic        carry;

  assign tick  = (pre_q == PRE_LAST);
  assign carry = tick && (lo_q == 32'hFFFF_FFFF);

  // A written half takes the store data and discards its own increment
  // (for the high half that increment is the carry from the low half).
  always_comb begin
    pre_d = tick ? 16'd0 : pre_q + 16'd1;
    lo_d  = lo_q;
    hi_d  = hi_q;
    if (wr_lo_i)   lo_d = wdata_i;
    else if (tick) lo_d = lo_q + 32'd1;
    if (wr_hi_i)    hi_d = wdata_i;
    else if (carry) hi_d = hi_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= 16'd0;
      lo_q  <= 32'd0;
      hi_q  <= 32'd0;
    end else begin
      pre_q <= pre_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
    end
  end

  assign mtime_o = {hi_q, lo_q};

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: machine-timer interrupt source (mtime/mtimecmp + request FSM).
//   clk, rst     : clock, async active-high reset
//   addr, wdata  : LSU byte address / store data
//   wr_en, rd_en : full-word store / load strobes
//   rdata        : combinational load data (0 when rd_en low or unmapped)
//   epc_taken    : CSR unit accepted the trap this cycle
//   is_mret      : MRET retiring
//   trap_handle  : registered interrupt request
//   mtip         : registered mtime >= mtimecmp
//
// state   | meaning
// IDLE    | no request; raise when mtip seen
// PENDING | trap_handle high, waiting for acceptance or withdrawal
// SERVICE | handler running; request held low until MRET
module timer_irq_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic [31:0] rdata,
  input  logic        epc_taken,
  input  logic        is_mret,
  output logic        trap_handle,
  output logic        mtip
);

  logic [63:0] mtime;
  logic [63:0] cmp_q, cmp_d;
  logic        mtip_q, trap_q;
  tirq_state_e state_q, state_d;

  logic wr_cmp_lo, wr_cmp_hi, wr_mt_lo, wr_mt_hi;

  assign wr_cmp_lo = wr_en && (addr == MTIMECMP_LO);
  assign wr_cmp_hi = wr_en && (addr == MTIMECMP_HI);
  assign wr_mt_lo  = wr_en && (addr == MTIME_LO);
  assign wr_mt_hi  = wr_en && (addr == MTIME_HI);

  mtime_counter #(.PRESCALE(PRESCALE)) u_mtime (
    .clk     (clk),
    .rst     (rst),
    .wr_lo_i (wr_mt_lo),
    .wr_hi_i (wr_mt_hi),
    .wdata_i (wdata),
    .mtime_o (mtime)
  );

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo) cmp_d[31:0]  = wdata;
    if (wr_cmp_hi) cmp_d[63:32] = wdata;
  end

  // FSM works off the registered mtip, so a compare change reaches the
  // request two edges later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mtip_q) state_d = PENDING;
      PENDING: begin
        if (epc_taken)    state_d = SERVICE;
        else if (!mtip_q) state_d = IDLE;
      end
      SERVICE: if (is_mret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtip_q  <= 1'b0;
      state_q <= IDLE;
      trap_q  <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      mtip_q  <= (mtime >= cmp_q);
      state_q <= state_d;
      trap_q  <= (state_d == PENDING);
    end
  end

  assign trap_handle = trap_q;
  assign mtip        = mtip_q;

  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      case (addr)
        MTIMECMP_LO: rdata = cmp_q[31:0];
        MTIMECMP_HI: rdata = cmp_q[63:32];
        MTIME_LO:    rdata = mtime[31:0];
        MTIME_HI:    rdata = mtime[63:32];
        default:     rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_irq_ctrl.sv
module tb_timer_irq_ctrl;
  import timer_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] rdata;
  logic        epc_taken;
  logic        is_mret;
  logic        trap_handle;
  logic        mtip;
  logic [31:0] rdata3;
  logic        trap3;
  logic        mtip3;

  int n_err;
  int n_checks;

  timer_irq_ctrl u_dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .rdata       (rdata),
    .epc_taken   (epc_taken),
    .is_mret     (is_mret),
    .trap_handle (trap_handle),
    .mtip        (mtip)
  );

  timer_irq_ctrl #(.PRESCALE(3)) u_dut_ps3 (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .wdata       (wdata),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .rdata       (rdata3),
    .epc_taken   (epc_taken),
    .is_mret     (is_mret),
    .trap_handle (trap3),
    .mtip        (mtip3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the store lands on the following posedge and the
  // task returns at the next negedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d3);
    addr  = a;
    rd_en = 1'b1;
    #1;
    d     = rdata;
    d3    = rdata3;
    rd_en = 1'b0;
  endtask

  task automatic pulse_epc();
    epc_taken = 1'b1;
    @(negedge clk);
    epc_taken = 1'b0;
  endtask

  task automatic pulse_mret();
    is_mret = 1'b1;
    @(negedge clk);
    is_mret = 1'b0;
  endtask

  logic [31:0] d, d3;

  initial begin
    n_err = 0; n_checks = 0;
    rst = 1'b1; addr = '0; wdata = '0; wr_en = 0; rd_en = 0;
    epc_taken = 0; is_mret = 0;
    repeat (2) @(negedge clk);

    // reset state, read while held in reset
    rd(MTIME_LO, d, d3);    check("rst_mtime_lo", d, 0);
    rd(MTIME_HI, d, d3);    check("rst_mtime_hi", d, 0);
    rd(MTIMECMP_LO, d, d3); check("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd(MTIMECMP_HI, d, d3); check("rst_cmp_hi", d, 32'hFFFF_FFFF);
    rd(32'h0200_4008, d, d3); check("rd_unmapped", d, 0);
    addr = MTIMECMP_LO; rd_en = 0; #1;
    check("rd_en_low", rdata, 0);
    check("rst_trap", trap_handle, 0);
    check("rst_mtip", mtip, 0);
    check("rst_trap_ps3", trap3, 0);
    check("rst_mtip_ps3", mtip3, 0);

    // prescale: 6 edges after release -> 6 and 2, edge 9 -> ps3 = 3
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    rd(MTIME_LO, d, d3);
    check("ps1_after6", d, 6);
    check("ps3_after6", d3, 2);
    repeat (2) @(negedge clk);
    rd(MTIME_LO, d, d3); check("ps3_after8", d3, 2);
    @(negedge clk);
    rd(MTIME_LO, d, d3); check("ps3_after9", d3, 3);

    // compare latency: cmp=10; mtime cleared at edge W
    wr(MTIMECMP_LO, 32'd10);
    wr(MTIME_LO, 32'd0);                 // after W
    rd(MTIME_LO, d, d3); check("mtime_written0", d, 0);
    wr(MTIMECMP_HI, 32'd0);              // after W+1
    repeat (9) @(negedge clk);           // after W+10
    rd(MTIME_LO, d, d3); check("mtime_is10", d, 10);
    check("mtip_before", mtip, 0);
    @(negedge clk);
    check("mtip_rise", mtip, 1);
    check("trap_lag", trap_handle, 0);
    @(negedge clk);
    check("trap_rise", trap_handle, 1);

    // accept, move compare ahead, mret -> no re-raise
    pulse_epc();
    check("trap_after_epc", trap_handle, 0);
    check("mtip_in_service", mtip, 1);
    wr(MTIMECMP_LO, 32'h100);
    pulse_mret();
    repeat (3) @(negedge clk);
    check("no_reraise_trap", trap_handle, 0);
    check("no_reraise_mtip", mtip, 0);

    // withdrawal while pending
    wr(MTIMECMP_LO, 32'd0);
    check("wd_mtip_lag", mtip, 0);
    @(negedge clk);
    check("wd_mtip", mtip, 1);
    @(negedge clk);
    check("wd_pending", trap_handle, 1);
    wr(MTIMECMP_LO, 32'hFFFF_FFFF);
    check("wd_hold0", trap_handle, 1);
    @(negedge clk);
    check("wd_mtip_fall", mtip, 0);
    check("wd_hold1", trap_handle, 1);
    @(negedge clk);
    check("wd_withdrawn", trap_handle, 0);
    repeat (2) @(negedge clk);
    check("wd_stays_idle", trap_handle, 0);

    // epc_taken together with !mtip -> SERVICE
    wr(MTIMECMP_LO, 32'd0);
    repeat (2) @(negedge clk);
    check("tie_pending", trap_handle, 1);
    wr(MTIMECMP_LO, 32'hFFFF_FFFF);
    @(negedge clk);
    check("tie_mtip_low", mtip, 0);
    pulse_epc();
    check("tie_trap_low", trap_handle, 0);
    wr(MTIMECMP_LO, 32'd0);
    repeat (4) @(negedge clk);
    check("tie_service_mtip", mtip, 1);
    check("tie_service_hold", trap_handle, 0);
    pulse_mret();
    check("mret_gap1", trap_handle, 0);
    @(negedge clk);
    check("mret_gap2", trap_handle, 1);

    // async reset mid-SERVICE
    pulse_epc();
    check("svc_before_rst", trap_handle, 0);
    #2; rst = 1'b1; #1;
    check("arst_trap", trap_handle, 0);
    check("arst_mtip", mtip, 0);
    rd(MTIME_LO, d, d3); check("arst_mtime", d, 0);
    rd(MTIMECMP_LO, d, d3); check("arst_cmp", d, 32'hFFFF_FFFF);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", trap_handle, 0);

    // unmapped write ignored
    wr(32'h0200_4008, 32'd0);
    rd(MTIMECMP_LO, d, d3); check("wr_unmapped", d, 32'hFFFF_FFFF);

    // carry low -> high
    wr(MTIME_LO, 32'hFFFF_FFFF);
    rd(MTIME_LO, d, d3); check("carry_lo_pre", d, 32'hFFFF_FFFF);
    rd(MTIME_HI, d, d3); check("carry_hi_pre", d, 0);
    @(negedge clk);
    rd(MTIME_LO, d, d3); check("carry_lo", d, 0);
    rd(MTIME_HI, d, d3); check("carry_hi", d, 1);

    // full wrap; mtime == mtimecmp boundary sets mtip
    wr(MTIME_HI, 32'hFFFF_FFFF);
    wr(MTIME_LO, 32'hFFFF_FFFF);
    rd(MTIME_LO, d, d3); check("ones_lo", d, 32'hFFFF_FFFF);
    rd(MTIME_HI, d, d3); check("ones_hi", d, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(MTIME_LO, d, d3); check("wrap_lo", d, 0);
    rd(MTIME_HI, d, d3); check("wrap_hi", d, 0);
    check("equal_mtip", mtip, 1);
    @(negedge clk);
    check("after_wrap_mtip", mtip, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
